// File: rtl/dac_readback_fsm_pkg.sv
// Shared definitions for the DAC readback and write-command FSMs:
// state encoding, ASCII protocol bytes and the default DAC address.
package dac_readback_fsm_pkg;

   localparam int unsigned STATE_W = 3;
   localparam int unsigned CODE_W  = 10;
   localparam int unsigned IDX_W   = 4;
   localparam int unsigned TMO_W   = 20;
   localparam int unsigned BYTE_W  = 8;

   localparam logic [STATE_W-1:0] ST_IDLE     = 3'd0;
   localparam logic [STATE_W-1:0] ST_I2C_REQ  = 3'd1;
   localparam logic [STATE_W-1:0] ST_I2C_WAIT = 3'd2;
   localparam logic [STATE_W-1:0] ST_TX_LOAD  = 3'd3;
   localparam logic [STATE_W-1:0] ST_TX_WAIT  = 3'd4;

   localparam logic [BYTE_W-1:0] ASCII_V_LC = 8'd118;
   localparam logic [BYTE_W-1:0] ASCII_V_UC = 8'd86;
   localparam logic [BYTE_W-1:0] ASCII_0    = 8'd48;
   localparam logic [BYTE_W-1:0] ASCII_1    = 8'd49;
   localparam logic [BYTE_W-1:0] ASCII_E    = 8'd69;
   localparam logic [BYTE_W-1:0] ASCII_CR   = 8'd13;
   localparam logic [BYTE_W-1:0] ASCII_LF   = 8'd10;

   localparam logic [6:0] DAC_ADDR_DEFAULT = 7'b0001101;

   // Index of the final byte of each reply ("v" + 10 digits + CR LF, or "E" CR LF)
   localparam logic [IDX_W-1:0] LAST_IDX_NORMAL = 4'd12;
   localparam logic [IDX_W-1:0] LAST_IDX_ERROR  = 4'd2;

endpackage

// File: rtl/dac_reply_rom.sv
// Maps reply byte index, captured code and error flag to the ASCII byte to send.
module dac_reply_rom
   import dac_readback_fsm_pkg::*;
(
   input  logic [IDX_W-1:0]  idx,
   input  logic [CODE_W-1:0] code,
   input  logic              err,
   output logic [BYTE_W-1:0] reply_byte_c
);

   logic [IDX_W-1:0] bit_sel_c;

   // Digits run from code bit 9 at index 1 down to bit 0 at index 10
   always_comb begin
      reply_byte_c = '0;
      bit_sel_c    = IDX_W'(10) - idx;
      if (err) begin
         case (idx)
            4'd0:    reply_byte_c = ASCII_E;
            4'd1:    reply_byte_c = ASCII_CR;
            4'd2:    reply_byte_c = ASCII_LF;
            default: reply_byte_c = '0;
         endcase
      end else if (idx == 4'd0) begin
         reply_byte_c = ASCII_V_LC;
      end else if (idx <= 4'd10) begin
         reply_byte_c = code[bit_sel_c] ? ASCII_1 : ASCII_0;
      end else if (idx == 4'd11) begin
         reply_byte_c = ASCII_CR;
      end else if (idx == 4'd12) begin
         reply_byte_c = ASCII_LF;
      end
   end

endmodule

// File: rtl/dac_readback_fsm.sv
// On a UART 'v', reads the DAC code over I2C and replies with its 10 bits in ASCII,
// or with "E\r\n" if the read does not complete in time.
module dac_readback_fsm
   import dac_readback_fsm_pkg::*;
#(
   parameter logic [6:0]       DAC_ADDR       = DAC_ADDR_DEFAULT,
   parameter logic [TMO_W-1:0] TIMEOUT_CYCLES = 20'd1000000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [7:0]        uart_rx,
   input  logic              uart_data_ready,
   output logic [7:0]        uart_tx,
   output logic              uart_tx_load,
   input  logic              uart_tx_busy,
   output logic [6:0]        i2c_addr,
   output logic [15:0]       i2c_data,
   output logic              i2c_bytes,
   output logic              i2c_r_w,
   output logic              i2c_load,
   input  logic              i2c_busy,
   input  logic              i2c_data_ready,
   input  logic [15:0]       i2c_rd_data
);

   localparam logic [TMO_W-1:0] TMO_LAST = TIMEOUT_CYCLES - TMO_W'(1);

   logic [STATE_W-1:0] state, nxt_state;
   logic [CODE_W-1:0]  code, nxt_code;
   logic               err, nxt_err;
   logic [IDX_W-1:0]   idx, nxt_idx;
   logic [TMO_W-1:0]   cnt, nxt_cnt;
   logic [BYTE_W-1:0]  nxt_tx;
   logic               nxt_tx_load, nxt_i2c_load;
   logic [BYTE_W-1:0]  reply_byte_c;
   logic               read_done_c, unused_rd_bits;

   assign i2c_addr  = DAC_ADDR;
   assign i2c_data  = 16'h0000;
   assign i2c_bytes = 1'b1;
   assign i2c_r_w   = 1'b1;

   // Only bits [11:2] of the read word carry the DAC code
   assign unused_rd_bits = ^{i2c_rd_data[15:12], i2c_rd_data[1:0]};

   assign read_done_c = i2c_data_ready || (cnt >= TMO_LAST);

   dac_reply_rom u_rom (
      .idx          (idx),
      .code         (code),
      .err          (err),
      .reply_byte_c (reply_byte_c)
   );

   // Next-state logic; the I2C request and the first reply byte are issued
   // straight from IDLE / I2C_WAIT when the target is free, saving a cycle each.
   always_comb begin
      nxt_state    = state;
      nxt_code     = code;
      nxt_err      = err;
      nxt_idx      = idx;
      nxt_cnt      = cnt;
      nxt_tx       = uart_tx;
      nxt_tx_load  = 1'b0;
      nxt_i2c_load = 1'b0;
      case (state)
         ST_IDLE, ST_I2C_REQ: begin
            if ((state == ST_I2C_REQ) || (uart_data_ready && (uart_rx == ASCII_V_LC))) begin
               if (!i2c_busy) begin
                  nxt_i2c_load = 1'b1;
                  nxt_cnt      = '0;
                  nxt_state    = ST_I2C_WAIT;
               end else begin
                  nxt_state    = ST_I2C_REQ;
               end
            end
         end
         ST_I2C_WAIT: begin
            nxt_cnt = cnt + TMO_W'(1);
            if (read_done_c) begin
               nxt_err = !i2c_data_ready;
               nxt_idx = '0;
               if (i2c_data_ready) begin
                  nxt_code = i2c_rd_data[11:2];
               end
               if (!uart_tx_busy) begin
                  nxt_tx      = i2c_data_ready ? ASCII_V_LC : ASCII_E;
                  nxt_tx_load = 1'b1;
                  nxt_state   = ST_TX_WAIT;
               end else begin
                  nxt_state   = ST_TX_LOAD;
               end
            end
         end
         ST_TX_LOAD: begin
            if (!uart_tx_busy) begin
               nxt_tx      = reply_byte_c;
               nxt_tx_load = 1'b1;
               nxt_state   = ST_TX_WAIT;
            end
         end
         ST_TX_WAIT: begin
            if (!uart_tx_busy) begin
               if (idx == (err ? LAST_IDX_ERROR : LAST_IDX_NORMAL)) begin
                  nxt_idx   = '0;
                  nxt_state = ST_IDLE;
               end else begin
                  nxt_idx   = idx + IDX_W'(1);
                  nxt_state = ST_TX_LOAD;
               end
            end
         end
         default: nxt_state = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= ST_IDLE;
         code         <= '0;
         err          <= 1'b0;
         idx          <= '0;
         cnt          <= '0;
         uart_tx      <= 8'h00;
         uart_tx_load <= 1'b0;
         i2c_load     <= 1'b0;
      end else begin
         state        <= nxt_state;
         code         <= nxt_code;
         err          <= nxt_err;
         idx          <= nxt_idx;
         cnt          <= nxt_cnt;
         uart_tx      <= nxt_tx;
         uart_tx_load <= nxt_tx_load;
         i2c_load     <= nxt_i2c_load;
      end
   end

endmodule

// File: tb/tb_dac_readback_fsm.sv
// Directed bench for dac_readback_fsm with a simple UART transmitter model.
module tb_dac_readback_fsm;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic [7:0]  uart_rx = 8'h00;
   logic        uart_data_ready = 1'b0;
   logic [7:0]  uart_tx;
   logic        uart_tx_load;
   logic        uart_tx_busy = 1'b0;
   logic [6:0]  i2c_addr;
   logic [15:0] i2c_data;
   logic        i2c_bytes;
   logic        i2c_r_w;
   logic        i2c_load;
   logic        i2c_busy = 1'b0;
   logic        i2c_data_ready = 1'b0;
   logic [15:0] i2c_rd_data = 16'h0000;

   int n_cmp = 0;
   int n_bad = 0;
   int tx_busy_len = 3;
   int tx_cnt = 0;
   int busy_viol = 0;
   int i2c_load_cnt = 0;
   logic [7:0] rxq[$];
   logic [7:0] expq[$];

   dac_readback_fsm #(
      .DAC_ADDR       (7'b0001101),
      .TIMEOUT_CYCLES (20'd100)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .uart_rx         (uart_rx),
      .uart_data_ready (uart_data_ready),
      .uart_tx         (uart_tx),
      .uart_tx_load    (uart_tx_load),
      .uart_tx_busy    (uart_tx_busy),
      .i2c_addr        (i2c_addr),
      .i2c_data        (i2c_data),
      .i2c_bytes       (i2c_bytes),
      .i2c_r_w         (i2c_r_w),
      .i2c_load        (i2c_load),
      .i2c_busy        (i2c_busy),
      .i2c_data_ready  (i2c_data_ready),
      .i2c_rd_data     (i2c_rd_data)
   );

   always #5 clk = ~clk;

   // UART transmitter model: captures loaded bytes, stays busy tx_busy_len cycles
   always @(negedge clk) begin
      if (uart_tx_load === 1'b1) begin
         if (uart_tx_busy) busy_viol++;
         rxq.push_back(uart_tx);
         tx_cnt = tx_busy_len;
      end else if (tx_cnt > 0) begin
         tx_cnt--;
      end
      uart_tx_busy = (tx_cnt > 0);
      if (i2c_load === 1'b1) i2c_load_cnt++;
   end

   task automatic send_uart(input logic [7:0] b);
      @(negedge clk);
      uart_rx = b;
      uart_data_ready = 1'b1;
      @(negedge clk);
      uart_data_ready = 1'b0;
   endtask

   task automatic pulse_i2c(input logic [15:0] d);
      @(negedge clk);
      i2c_rd_data = d;
      i2c_data_ready = 1'b1;
      @(negedge clk);
      i2c_data_ready = 1'b0;
   endtask

   task automatic wait_bytes(input int n, input int budget, output bit ok);
      int c = 0;
      while (rxq.size() < n && c < budget) begin
         @(negedge clk);
         c++;
      end
      ok = (rxq.size() >= n);
   endtask

   function automatic void set_expected(input string s);
      expq.delete();
      for (int i = 0; i < s.len(); i++) expq.push_back(s[i]);
      expq.push_back(8'd13);
      expq.push_back(8'd10);
   endfunction

   task automatic test_reset();
      #3 rst_n = 1'b0;
      #2;
      n_cmp++; if (uart_tx !== 8'h00) begin n_bad++; $display("FAIL reset_uart_tx: got %0h want 0", uart_tx); end
      n_cmp++; if (uart_tx_load !== 1'b0) begin n_bad++; $display("FAIL reset_tx_load: got %b want 0", uart_tx_load); end
      n_cmp++; if (i2c_load !== 1'b0) begin n_bad++; $display("FAIL reset_i2c_load: got %b want 0", i2c_load); end
      n_cmp++; if (i2c_addr !== 7'h0D) begin n_bad++; $display("FAIL i2c_addr: got %0h want d", i2c_addr); end
      n_cmp++; if (i2c_data !== 16'h0000) begin n_bad++; $display("FAIL i2c_data: got %0h want 0", i2c_data); end
      n_cmp++; if ({i2c_bytes, i2c_r_w} !== 2'b11) begin n_bad++; $display("FAIL i2c_bytes_rw: got %b want 11", {i2c_bytes, i2c_r_w}); end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      n_cmp++; if ({uart_tx_load, i2c_load} !== 2'b00) begin n_bad++; $display("FAIL post_reset_strobes: got %b want 00", {uart_tx_load, i2c_load}); end
   endtask

   task automatic test_read(input logic [15:0] rd, input string digits, input string name);
      bit ok;
      int base;
      rxq.delete();
      set_expected({"v", digits});
      base = i2c_load_cnt;
      send_uart(8'd118);
      n_cmp++; if (i2c_load !== 1'b1) begin n_bad++; $display("FAIL %s_i2c_latency: got %b want 1", name, i2c_load); end
      n_cmp++; if ({i2c_addr, i2c_r_w} !== {7'h0D, 1'b1}) begin n_bad++; $display("FAIL %s_addr_rw: got %0h want 1b", name, {i2c_addr, i2c_r_w}); end
      @(negedge clk);
      n_cmp++; if (i2c_load !== 1'b0) begin n_bad++; $display("FAIL %s_i2c_width: got %b want 0", name, i2c_load); end
      repeat (4) @(negedge clk);
      pulse_i2c(rd);
      n_cmp++; if ({uart_tx_load, uart_tx} !== {1'b1, 8'd118}) begin n_bad++; $display("FAIL %s_tx_latency: got %0h want 176", name, {uart_tx_load, uart_tx}); end
      wait_bytes(13, 2000, ok);
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL %s_reply_timeout: got %0d bytes want 13", name, rxq.size()); end
      for (int i = 0; i < 13; i++) begin
         if (i < rxq.size()) begin
            n_cmp++; if (rxq[i] !== expq[i]) begin n_bad++; $display("FAIL %s_byte%0d: got %0h want %0h", name, i, rxq[i], expq[i]); end
         end
      end
      repeat (20) @(negedge clk);
      n_cmp++; if (rxq.size() != 13) begin n_bad++; $display("FAIL %s_count: got %0d want 13", name, rxq.size()); end
      n_cmp++; if (busy_viol != 0) begin n_bad++; $display("FAIL %s_load_while_busy: got %0d want 0", name, busy_viol); end
      n_cmp++; if (i2c_load_cnt != base + 1) begin n_bad++; $display("FAIL %s_i2c_loads: got %0d want %0d", name, i2c_load_cnt, base + 1); end
   endtask

   task automatic test_timeout();
      bit ok;
      int cyc;
      rxq.delete();
      set_expected("E");
      send_uart(8'd118);
      n_cmp++; if (i2c_load !== 1'b1) begin n_bad++; $display("FAIL tmo_i2c_load: got %b want 1", i2c_load); end
      cyc = 0;
      while (uart_tx_load !== 1'b1 && cyc < 400) begin
         @(negedge clk);
         cyc++;
      end
      n_cmp++; if (cyc != 100) begin n_bad++; $display("FAIL tmo_cycles: got %0d want 100", cyc); end
      n_cmp++; if (uart_tx !== 8'd69) begin n_bad++; $display("FAIL tmo_first_byte: got %0h want 45", uart_tx); end
      pulse_i2c(16'h0FFC);
      wait_bytes(3, 500, ok);
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL tmo_reply_timeout: got %0d bytes want 3", rxq.size()); end
      for (int i = 0; i < 3; i++) begin
         if (i < rxq.size()) begin
            n_cmp++; if (rxq[i] !== expq[i]) begin n_bad++; $display("FAIL tmo_byte%0d: got %0h want %0h", i, rxq[i], expq[i]); end
         end
      end
      repeat (20) @(negedge clk);
      n_cmp++; if (rxq.size() != 3) begin n_bad++; $display("FAIL tmo_count: got %0d want 3", rxq.size()); end
      rxq.delete();
      send_uart(8'd118);
      n_cmp++; if (i2c_load !== 1'b1) begin n_bad++; $display("FAIL tmo_idle_after: got %b want 1", i2c_load); end
      repeat (3) @(negedge clk);
      pulse_i2c(16'h0000);
      wait_bytes(13, 500, ok);
      repeat (20) @(negedge clk);
      n_cmp++; if (rxq.size() != 13) begin n_bad++; $display("FAIL tmo_next_count: got %0d want 13", rxq.size()); end
   endtask

   task automatic test_i2c_busy();
      bit ok;
      int base;
      rxq.delete();
      set_expected("v1010010101");
      base = i2c_load_cnt;
      i2c_busy = 1'b1;
      send_uart(8'd118);
      repeat (49) @(negedge clk);
      n_cmp++; if (i2c_load_cnt != base) begin n_bad++; $display("FAIL busy_no_load: got %0d want %0d", i2c_load_cnt, base); end
      i2c_busy = 1'b0;
      @(negedge clk);
      n_cmp++; if (i2c_load !== 1'b1) begin n_bad++; $display("FAIL busy_release_load: got %b want 1", i2c_load); end
      @(negedge clk);
      n_cmp++; if (i2c_load !== 1'b0) begin n_bad++; $display("FAIL busy_load_width: got %b want 0", i2c_load); end
      repeat (3) @(negedge clk);
      pulse_i2c(16'h0A54);
      wait_bytes(3, 500, ok);
      send_uart(8'd118);
      wait_bytes(13, 1000, ok);
      repeat (30) @(negedge clk);
      n_cmp++; if (rxq.size() != 13) begin n_bad++; $display("FAIL busy_count: got %0d want 13", rxq.size()); end
      n_cmp++; if (i2c_load_cnt != base + 1) begin n_bad++; $display("FAIL busy_second_v: got %0d want %0d", i2c_load_cnt, base + 1); end
      for (int i = 0; i < 13; i++) begin
         if (i < rxq.size()) begin
            n_cmp++; if (rxq[i] !== expq[i]) begin n_bad++; $display("FAIL busy_byte%0d: got %0h want %0h", i, rxq[i], expq[i]); end
         end
      end
   endtask

   task automatic test_tx_busy();
      bit ok;
      int viol0;
      rxq.delete();
      set_expected("v0110011001");
      viol0 = busy_viol;
      tx_busy_len = 200;
      send_uart(8'd118);
      repeat (2) @(negedge clk);
      pulse_i2c(16'hF665);
      wait_bytes(13, 3500, ok);
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL txbusy_reply_timeout: got %0d bytes want 13", rxq.size()); end
      for (int i = 0; i < 13; i++) begin
         if (i < rxq.size()) begin
            n_cmp++; if (rxq[i] !== expq[i]) begin n_bad++; $display("FAIL txbusy_byte%0d: got %0h want %0h", i, rxq[i], expq[i]); end
         end
      end
      repeat (210) @(negedge clk);
      n_cmp++; if (busy_viol != viol0) begin n_bad++; $display("FAIL txbusy_load_while_busy: got %0d want %0d", busy_viol, viol0); end
      n_cmp++; if (rxq.size() != 13) begin n_bad++; $display("FAIL txbusy_count: got %0d want 13", rxq.size()); end
      tx_busy_len = 3;
   endtask

   task automatic test_reset_mid();
      bit ok;
      int pre;
      int lc;
      rxq.delete();
      tx_busy_len = 20;
      send_uart(8'd118);
      repeat (2) @(negedge clk);
      pulse_i2c(16'h0A54);
      wait_bytes(6, 1000, ok);
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL rstmid_reach6: got %0d bytes want 6", rxq.size()); end
      #1 rst_n = 1'b0;
      #1;
      n_cmp++; if ({uart_tx_load, i2c_load, uart_tx} !== 10'h000) begin n_bad++; $display("FAIL rstmid_strobes: got %0h want 0", {uart_tx_load, i2c_load, uart_tx}); end
      pre = rxq.size();
      lc = i2c_load_cnt;
      repeat (10) @(negedge clk);
      rst_n = 1'b1;
      repeat (30) @(negedge clk);
      n_cmp++; if (rxq.size() != pre) begin n_bad++; $display("FAIL rstmid_abandon: got %0d want %0d", rxq.size(), pre); end
      n_cmp++; if (i2c_load_cnt != lc) begin n_bad++; $display("FAIL rstmid_i2c: got %0d want %0d", i2c_load_cnt, lc); end
      rxq.delete();
      set_expected("v1010010101");
      send_uart(8'd118);
      n_cmp++; if (i2c_load !== 1'b1) begin n_bad++; $display("FAIL rstmid_first_v: got %b want 1", i2c_load); end
      repeat (2) @(negedge clk);
      pulse_i2c(16'h0A54);
      wait_bytes(13, 1000, ok);
      for (int i = 0; i < 13; i++) begin
         if (i < rxq.size()) begin
            n_cmp++; if (rxq[i] !== expq[i]) begin n_bad++; $display("FAIL rstmid_byte%0d: got %0h want %0h", i, rxq[i], expq[i]); end
         end
      end
      repeat (30) @(negedge clk);
      n_cmp++; if (rxq.size() != 13) begin n_bad++; $display("FAIL rstmid_count: got %0d want 13", rxq.size()); end
      tx_busy_len = 3;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_read(16'h0A54, "1010010101", "read_a54");
      test_read(16'h0FFC, "1111111111", "read_ffc");
      test_read(16'h0000, "0000000000", "read_000");
      test_timeout();
      test_i2c_busy();
      test_tx_busy();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
